// File: rtl/sh7604_ibus_master.sv
// SH7604 internal-bus master: turns a CPU level request into one IBUS cycle.
// Optional WAIT-state bus timeout enabled by defining SH7604_IBUS_TIMEOUT_EN.
module sh7604_ibus_master #(
    parameter logic [7:0] TO_LIMIT = 8'd255
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CE_R,
    input  logic        EN,
    input  logic [31:0] CPU_A,
    input  logic [31:0] CPU_DI,
    input  logic        CPU_WE,
    input  logic [1:0]  CPU_SZ,
    input  logic        CPU_REQ,
    output logic [31:0] CPU_DO,
    output logic        CPU_ACK,
    output logic        CPU_AERR,
    output logic        CPU_BERR,
    output logic [31:0] IBUS_A,
    output logic [31:0] IBUS_DO,
    input  logic [31:0] IBUS_DI,
    output logic [3:0]  IBUS_BA,
    output logic        IBUS_WE,
    output logic        IBUS_REQ,
    input  logic        IBUS_BUSY
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t      state_q;
    logic [1:0]  sz_q;
    logic [31:0] ibus_a_q;
    logic [31:0] ibus_do_q;
    logic [3:0]  ibus_ba_q;
    logic        ibus_we_q;
    logic        ibus_req_q;
    logic [31:0] cpu_do_q;
    logic        ack_q;
    logic        aerr_q;

    logic        aligned_d;
    logic [3:0]  ba_d;
    logic [31:0] wdo_d;
    logic [31:0] rdo_d;

    // Request-side decode: alignment, byte lanes and replicated write data
    always_comb begin
        aligned_d = 1'b1;
        ba_d      = 4'b1111;
        wdo_d     = CPU_DI;
        case (CPU_SZ)
            2'b00: begin
                ba_d  = 4'b1000 >> CPU_A[1:0];
                wdo_d = {4{CPU_DI[7:0]}};
            end
            2'b01: begin
                aligned_d = ~CPU_A[0];
                ba_d      = CPU_A[1] ? 4'b0011 : 4'b1100;
                wdo_d     = {2{CPU_DI[15:0]}};
            end
            default: begin
                aligned_d = (CPU_A[1:0] == 2'b00);
            end
        endcase
    end

    // Big-endian lane extraction, zero-extended
    always_comb begin
        rdo_d = IBUS_DI;
        case (sz_q)
            2'b00: begin
                case (ibus_a_q[1:0])
                    2'd0:    rdo_d = {24'd0, IBUS_DI[31:24]};
                    2'd1:    rdo_d = {24'd0, IBUS_DI[23:16]};
                    2'd2:    rdo_d = {24'd0, IBUS_DI[15:8]};
                    default: rdo_d = {24'd0, IBUS_DI[7:0]};
                endcase
            end
            2'b01: begin
                rdo_d = ibus_a_q[1] ? {16'd0, IBUS_DI[15:0]}
                                    : {16'd0, IBUS_DI[31:16]};
            end
            default: rdo_d = IBUS_DI;
        endcase
    end

`ifdef SH7604_IBUS_TIMEOUT_EN
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       berr_q;

    assign cnt_d    = cnt_q + 8'd1;
    assign CPU_BERR = berr_q;
`else
    logic unused_to;

    assign unused_to = ^TO_LIMIT;
    assign CPU_BERR  = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            sz_q       <= 2'b00;
            ibus_a_q   <= 32'd0;
            ibus_do_q  <= 32'd0;
            ibus_ba_q  <= 4'b0000;
            ibus_we_q  <= 1'b0;
            ibus_req_q <= 1'b0;
            cpu_do_q   <= 32'd0;
            ack_q      <= 1'b0;
            aerr_q     <= 1'b0;
`ifdef SH7604_IBUS_TIMEOUT_EN
            cnt_q      <= 8'd0;
            berr_q     <= 1'b0;
`endif
        end else if (CE_R && EN) begin
            case (state_q)
                IDLE: begin
                    if (CPU_REQ) begin
                        sz_q     <= CPU_SZ;
                        cpu_do_q <= 32'd0;
                        aerr_q   <= 1'b0;
`ifdef SH7604_IBUS_TIMEOUT_EN
                        berr_q   <= 1'b0;
`endif
                        if (aligned_d) begin
                            ibus_a_q   <= CPU_A;
                            ibus_we_q  <= CPU_WE;
                            ibus_ba_q  <= ba_d;
                            ibus_do_q  <= wdo_d;
                            ibus_req_q <= 1'b1;
                            state_q    <= ISSUE;
                        end else begin
                            aerr_q  <= 1'b1;
                            ack_q   <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                ISSUE: begin
`ifdef SH7604_IBUS_TIMEOUT_EN
                    cnt_q   <= 8'd0;
`endif
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (!IBUS_BUSY) begin
                        if (!ibus_we_q) begin
                            cpu_do_q <= rdo_d;
                        end
                        ibus_req_q <= 1'b0;
                        ack_q      <= 1'b1;
                        state_q    <= DONE;
                    end
`ifdef SH7604_IBUS_TIMEOUT_EN
                    else if (cnt_d == TO_LIMIT) begin
                        cnt_q      <= cnt_d;
                        cpu_do_q   <= 32'hFFFF_FFFF;
                        berr_q     <= 1'b1;
                        ibus_req_q <= 1'b0;
                        ack_q      <= 1'b1;
                        state_q    <= DONE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
`endif
                end
                DONE: begin
                    ack_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign CPU_DO   = cpu_do_q;
    assign CPU_ACK  = ack_q;
    assign CPU_AERR = aerr_q;
    assign IBUS_A   = ibus_a_q;
    assign IBUS_DO  = ibus_do_q;
    assign IBUS_BA  = ibus_ba_q;
    assign IBUS_WE  = ibus_we_q;
    assign IBUS_REQ = ibus_req_q;

endmodule

// File: tb/tb_sh7604_ibus_master.sv
// Scoreboard bench for sh7604_ibus_master with a simple busy-count responder.
// Build with SH7604_IBUS_TIMEOUT_EN to exercise the bus timeout path.
module tb_sh7604_ibus_master;

    localparam logic [7:0] TO = 8'd4;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        CE_R;
    logic        EN;
    logic [31:0] CPU_A;
    logic [31:0] CPU_DI;
    logic        CPU_WE;
    logic [1:0]  CPU_SZ;
    logic        CPU_REQ;
    logic [31:0] CPU_DO;
    logic        CPU_ACK;
    logic        CPU_AERR;
    logic        CPU_BERR;
    logic [31:0] IBUS_A;
    logic [31:0] IBUS_DO;
    logic [31:0] IBUS_DI;
    logic [3:0]  IBUS_BA;
    logic        IBUS_WE;
    logic        IBUS_REQ;
    logic        IBUS_BUSY;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] cdo;
        logic        aerr;
        logic        berr;
        int          lat;
        int          reqs;
    } exp_t;

    exp_t sb[$];

    sh7604_ibus_master #(.TO_LIMIT(TO)) dut (
        .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .EN(EN),
        .CPU_A(CPU_A), .CPU_DI(CPU_DI), .CPU_WE(CPU_WE),
        .CPU_SZ(CPU_SZ), .CPU_REQ(CPU_REQ), .CPU_DO(CPU_DO),
        .CPU_ACK(CPU_ACK), .CPU_AERR(CPU_AERR), .CPU_BERR(CPU_BERR),
        .IBUS_A(IBUS_A), .IBUS_DO(IBUS_DO), .IBUS_DI(IBUS_DI),
        .IBUS_BA(IBUS_BA), .IBUS_WE(IBUS_WE), .IBUS_REQ(IBUS_REQ),
        .IBUS_BUSY(IBUS_BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic m_aligned(input logic [31:0] a,
                                       input logic [1:0] sz);
        if (sz == 2'b10) return a[1:0] == 2'b00;
        if (sz == 2'b01) return a[0] == 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [3:0] m_ba(input logic [31:0] a,
                                        input logic [1:0] sz);
        if (sz == 2'b10) return 4'hF;
        if (sz == 2'b01) return a[1] ? 4'h3 : 4'hC;
        return 4'(8 >> a[1:0]);
    endfunction

    function automatic logic [31:0] m_wdo(input logic [31:0] di,
                                          input logic [1:0] sz);
        if (sz == 2'b10) return di;
        if (sz == 2'b01) return {di[15:0], di[15:0]};
        return {di[7:0], di[7:0], di[7:0], di[7:0]};
    endfunction

    function automatic logic [31:0] m_rdo(input logic [31:0] a,
                                          input logic [1:0] sz,
                                          input logic [31:0] d);
        int sh;
        if (sz == 2'b10) return d;
        if (sz == 2'b01) begin
            sh = a[1] ? 0 : 16;
            return (d >> sh) & 32'h0000_FFFF;
        end
        sh = 8 * (3 - int'(a[1:0]));
        return (d >> sh) & 32'h0000_00FF;
    endfunction

    task automatic access(input string tag, input logic [31:0] a,
                          input logic [31:0] di, input logic we,
                          input logic [1:0] sz, input int nbusy,
                          input logic [31:0] rdata, input bit hold);
        exp_t e;
        exp_t g;
        bit   ok;
        bit   done;
        int   k;
        int   reqs;
        logic [3:0]  eba;
        logic [31:0] edo;

        ok  = m_aligned(a, sz);
        eba = m_ba(a, sz);
        edo = m_wdo(di, sz);
        e.aerr = !ok;
        e.berr = 1'b0;
        e.cdo  = (!ok || we) ? 32'd0 : m_rdo(a, sz, rdata);
        e.lat  = ok ? 3 + nbusy : 1;
        e.reqs = ok ? 2 + nbusy : 0;
`ifdef SH7604_IBUS_TIMEOUT_EN
        if (ok && nbusy >= int'(TO)) begin
            e.berr = 1'b1;
            e.cdo  = 32'hFFFF_FFFF;
            e.lat  = int'(TO) + 2;
            e.reqs = int'(TO) + 1;
        end
`endif
        sb.push_back(e);

        CPU_A     = a;
        CPU_DI    = di;
        CPU_WE    = we;
        CPU_SZ    = sz;
        IBUS_DI   = rdata;
        IBUS_BUSY = 1'b0;
        CPU_REQ   = 1'b1;
        done = 1'b0;
        reqs = 0;
        k    = 0;
        while (!done && k < nbusy + 40) begin
            if (hold && k == 2) begin
                EN = 1'b0;
                repeat (3) begin
                    tick();
                    chk({tag, ".hold_req"}, 32'(IBUS_REQ), 1);
                    chk({tag, ".hold_ack"}, 32'(CPU_ACK), 0);
                end
                EN = 1'b1;
            end
            tick();
            if (IBUS_REQ) reqs++;
            if (k == 0 && ok) begin
                chk({tag, ".ba"}, 32'(IBUS_BA), 32'(eba));
                chk({tag, ".ido"}, IBUS_DO, edo);
                chk({tag, ".aerr_clr"}, 32'(CPU_AERR), 0);
            end
            IBUS_BUSY = IBUS_REQ && k >= 1 && k <= nbusy;
            if (CPU_ACK) begin
                g = sb.pop_front();
                chk({tag, ".do"}, CPU_DO, g.cdo);
                chk({tag, ".aerr"}, 32'(CPU_AERR), 32'(g.aerr));
                chk({tag, ".berr"}, 32'(CPU_BERR), 32'(g.berr));
                chk({tag, ".lat"}, 32'(k + 1), 32'(g.lat));
                chk({tag, ".reqs"}, 32'(reqs), 32'(g.reqs));
                chk({tag, ".req_fall"}, 32'(IBUS_REQ), 0);
                if (ok) begin
                    chk({tag, ".a_hold"}, IBUS_A, a);
                    chk({tag, ".we_hold"}, 32'(IBUS_WE), 32'(we));
                    chk({tag, ".ba_hold"}, 32'(IBUS_BA), 32'(eba));
                end
                CPU_REQ = 1'b0;
                done = 1'b1;
            end
            k++;
        end
        chk({tag, ".acked"}, 32'(done), 1);
        if (!done) begin
            CPU_REQ = 1'b0;
            sb.delete();
        end
        IBUS_BUSY = 1'b0;
        tick();
        chk({tag, ".ack_1tick"}, 32'(CPU_ACK), 0);
    endtask

    initial begin
        RST_N = 1'b0;
        CE_R = 1'b1;
        EN = 1'b1;
        CPU_A = '0;
        CPU_DI = '0;
        CPU_WE = 1'b0;
        CPU_SZ = 2'b00;
        CPU_REQ = 1'b0;
        IBUS_DI = '0;
        IBUS_BUSY = 1'b0;
        repeat (2) tick();
        chk("rst.req", 32'(IBUS_REQ), 0);
        chk("rst.we", 32'(IBUS_WE), 0);
        chk("rst.ba", 32'(IBUS_BA), 0);
        chk("rst.a", IBUS_A, 0);
        chk("rst.ido", IBUS_DO, 0);
        chk("rst.cdo", CPU_DO, 0);
        chk("rst.ack", 32'(CPU_ACK), 0);
        chk("rst.aerr", 32'(CPU_AERR), 0);
        chk("rst.berr", 32'(CPU_BERR), 0);
        RST_N = 1'b1;
        tick();

        access("lw", 32'hFFFF_FE80, 32'hA55A_1234, 1'b1, 2'b10, 0, 0, 0);
        access("ww", 32'hFFFF_FE80, 32'h0000_5A5A, 1'b1, 2'b01, 0, 0, 0);
        access("br", 32'hFFFF_FE81, 32'h0, 1'b0, 2'b00, 2,
               32'h1122_3344, 0);
        access("wr_mis", 32'hFFFF_FE83, 32'h0, 1'b0, 2'b01, 0,
               32'h1122_3344, 0);
        access("lr", 32'h0000_1000, 32'h0, 1'b0, 2'b10, 1,
               32'hDEAD_BEEF, 1);
        access("bw3", 32'h0000_2003, 32'h0000_0077, 1'b1, 2'b00, 0, 0, 0);
        access("wr2", 32'h0000_2002, 32'h0, 1'b0, 2'b01, 3,
               32'hCAFE_F00D, 0);
        access("lr_mis", 32'h0000_2002, 32'h0, 1'b0, 2'b10, 0, 0, 0);
        access("br0", 32'h0000_3000, 32'h0, 1'b0, 2'b00, 0,
               32'h9ABC_DEF0, 0);

`ifdef SH7604_IBUS_TIMEOUT_EN
        access("tmo", 32'h0000_4000, 32'h0, 1'b0, 2'b10, 1000,
               32'h1234_5678, 0);
`else
        begin
            int acks;
            acks = 0;
            CPU_A = 32'h0000_4000;
            CPU_SZ = 2'b10;
            CPU_WE = 1'b0;
            IBUS_BUSY = 1'b1;
            CPU_REQ = 1'b1;
            repeat (1000) begin
                tick();
                if (CPU_ACK) acks++;
            end
            chk("stuck.acks", 32'(acks), 0);
            chk("stuck.req", 32'(IBUS_REQ), 1);
            CPU_REQ = 1'b0;
            RST_N = 1'b0;
            tick();
            RST_N = 1'b1;
            IBUS_BUSY = 1'b0;
            tick();
        end
`endif

        CPU_A = 32'h0000_5000;
        CPU_SZ = 2'b10;
        CPU_WE = 1'b0;
        IBUS_BUSY = 1'b1;
        CPU_REQ = 1'b1;
        repeat (4) tick();
        chk("wrst.pre_req", 32'(IBUS_REQ), 1);
        CPU_REQ = 1'b0;
        RST_N = 1'b0;
        tick();
        chk("wrst.req", 32'(IBUS_REQ), 0);
        chk("wrst.ack", 32'(CPU_ACK), 0);
        RST_N = 1'b1;
        IBUS_BUSY = 1'b0;
        tick();
        chk("wrst.idle_ack", 32'(CPU_ACK), 0);
        access("post_rst", 32'h0000_6004, 32'h0, 1'b0, 2'b01, 1,
               32'h0BAD_CAFE, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sh7604_ibus_master.md
SH7604_IBUS_MASTER -- requirements
Module: SH7604_IBUS_MASTER

Interface
REQ-001 SHALL have parameter TO_LIMIT, default 8'd255, meaning the number of CE_R ticks allowed in WAIT before abort (used only with SH7604_IBUS_TIMEOUT_EN).
REQ-002 SHALL have ports CLK input 1 (system clock) and RST_N input 1 (reset: synchronous, active-low, sampled on posedge CLK).
REQ-003 SHALL have CE_R input 1 (rising-phase enable; all state advances) and EN input 1 (global enable; when low, state and outputs hold).
REQ-004 SHALL have CPU_A input 32, CPU_DI input 32, CPU_WE input 1, CPU_SZ input 2 (00 byte, 01 word, 10 long) and CPU_REQ input 1 (level request; held until CPU_ACK).
REQ-005 SHALL have CPU_DO output 32, CPU_ACK output 1, CPU_AERR output 1 (misaligned access) and CPU_BERR output 1 (timeout).
REQ-006 SHALL have IBUS_A output 32, IBUS_DO output 32 (write data), IBUS_DI input 32 (read data), IBUS_BA output 4, IBUS_WE output 1, IBUS_REQ output 1 and IBUS_BUSY input 1.

Function
REQ-007 SHALL step its FSM only on CE_R && EN, with states IDLE, ISSUE, WAIT and DONE.
REQ-008 In IDLE with CPU_REQ=1, SHALL latch A, WE, SZ and DI, and SHALL check alignment: word needs A[0]=0; long needs A[1:0]=00.
REQ-009 On a misaligned access, SHALL issue no bus cycle, SHALL set CPU_AERR=1, and SHALL go to DONE.
REQ-010 On an aligned access, SHALL set IBUS_REQ=1 and go to ISSUE.
REQ-011 SHALL generate IBUS_BA big-endian, BA[3] = bits 31:24.
- Byte: A[1:0]=0..3 gives 1000, 0100, 0010, 0001.
- Word: A[1]=0 gives 1100; A[1]=1 gives 0011.
- Long: 1111.
REQ-012 SHALL replicate write data across lanes: byte {4{DI[7:0]}}, word {2{DI[15:0]}}, long DI.
REQ-013 SHALL hold IBUS_A, IBUS_BA, IBUS_WE and IBUS_DO stable from ISSUE entry until IDLE re-entry.
REQ-014 ISSUE SHALL last exactly one CE_R tick and then go to WAIT, so the responder sees the REQ rising edge before BUSY is sampled.
REQ-015 In WAIT, SHALL stay while IBUS_BUSY=1. On the first CE_R tick with IBUS_BUSY=0 it SHALL:
- capture read data;
- drive IBUS_REQ=0;
- go to DONE.
REQ-016 Read extraction SHALL zero-extend the selected lane into CPU_DO: byte lane per A[1:0] (0 gives IBUS_DI[31:24]), word half per A[1] (0 gives [31:16]), long as-is.
REQ-017 CPU_ACK SHALL be 1 for exactly one CE_R tick (in DONE), then the FSM returns to IDLE. The write commits at the responder on that tick (REQ falling edge).
REQ-018 CPU_DO, CPU_AERR and CPU_BERR SHALL be valid while CPU_ACK=1 and held until the next accept. AERR and BERR SHALL clear on accept.
REQ-019 Minimum latency, accept tick to ACK tick, SHALL be 3 CE_R ticks with IBUS_BUSY always 0, and 3+N with N busy ticks in WAIT.
REQ-020 SHALL ignore a CPU_REQ while not in IDLE. A CPU_REQ still high on return to IDLE SHALL start a new access.
REQ-021 With EN=0 mid-access, SHALL freeze state and keep IBUS_REQ at its current value.

Reset
REQ-022 With RST_N=0 at posedge CLK, SHALL go to IDLE regardless of CE_R/EN, and set IBUS_REQ=0, IBUS_WE=0, IBUS_BA=0000, IBUS_A=0, IBUS_DO=0, CPU_DO=0, CPU_ACK=0, CPU_AERR=0, CPU_BERR=0, with the timeout counter at 0.
REQ-023 Reset during ISSUE or WAIT SHALL abort the access without CPU_ACK. IBUS_REQ SHALL be 0 on the first clock after reset.

Configuration
REQ-024 With SH7604_IBUS_TIMEOUT_EN defined, SHALL count in an 8-bit counter the CE_R ticks spent in WAIT with IBUS_BUSY=1, cleared on WAIT entry.
REQ-025 With the macro defined, when the count reaches TO_LIMIT, SHALL drop IBUS_REQ, set CPU_DO=FFFFFFFF and CPU_BERR=1, and go to DONE.
REQ-026 Without the macro, SHALL have no counter, SHALL wait in WAIT indefinitely, and CPU_BERR SHALL be tied 0.

Verification
REQ-027 Long write, A=FFFFFE80, DI=A55A1234, BUSY=0 -> IBUS_BA=1111, IBUS_DO=A55A1234; REQ high for 2 ticks; ACK on tick 3.
REQ-028 Word write, A=FFFFFE80, DI=5A5A -> IBUS_BA=1100, IBUS_DO=5A5A5A5A; a responder model sees the REQ falling edge on the ACK tick.
REQ-029 Byte read, A=FFFFFE81, responder drives IBUS_DI=11223344 after 2 busy ticks -> CPU_DO=00000022; ACK at tick 5.
REQ-030 Word read at A=...83 -> CPU_AERR=1, IBUS_REQ never asserted, ACK at the tick after accept.
REQ-031 With macro, TO_LIMIT=4, IBUS_BUSY stuck 1 -> CPU_BERR=1, CPU_DO=FFFFFFFF, IBUS_REQ=0; without macro, no ACK after 1000 ticks.
REQ-032 RST_N=0 while in WAIT -> IBUS_REQ=0 on the next clock, no ACK, and the next CPU_REQ completes normally.
